// File: rtl/hls_vec_adder.sv
// ap_ctrl_hs vector adder: reads N_WORDS operands, writes back their sum modulo 2^DATA_W,
// then pulses ap_done. Memory outputs are decoded from registered state and counters.
module hls_vec_adder #(
  parameter int DATA_W    = 32,
  parameter int ADDR_W    = 3,
  parameter int N_WORDS   = 4,
  parameter int BASE_ADDR = 0,
  parameter int RES_ADDR  = 7,
  parameter int MEM_LAT   = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ap_start,
  output logic              ap_idle,
  output logic              ap_ready,
  output logic              ap_done,
  output logic              mem_ren,
  output logic              mem_wen,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_datw,
  input  logic [DATA_W-1:0] mem_datr,
  output logic [DATA_W-1:0] sum_out,
  output logic              overflow
);

  localparam int WT_W = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;
  localparam logic [ADDR_W-1:0] RD_LAST = ADDR_W'(N_WORDS - 1);
  localparam logic [WT_W-1:0]   WT_LAST = WT_W'(MEM_LAT - 1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_READ  = 3'd1,
    S_WAIT  = 3'd2,
    S_WRITE = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  state_t              state, state_nxt;
  logic [ADDR_W-1:0]   rd_cnt;
  logic [WT_W-1:0]     wt_cnt;
  logic [DATA_W-1:0]   acc;
  logic [DATA_W:0]     acc_sum;
  logic [MEM_LAT:1]    vld_pipe;
  logic                start_txn;

  assign start_txn = (state == S_IDLE) && ap_start;
  assign acc_sum   = {1'b0, acc} + {1'b0, mem_datr};

  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (ap_start) state_nxt = S_READ;
      S_READ:  if (rd_cnt == RD_LAST) state_nxt = S_WAIT;
      // final read's data lands in the last WAIT cycle, so leaving then keeps WRITE exact
      S_WAIT:  if (wt_cnt == WT_LAST) state_nxt = S_WRITE;
      S_WRITE: state_nxt = S_DONE;
      S_DONE:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    ap_idle  = (state == S_IDLE);
    mem_ren  = (state == S_READ);
    ap_ready = (state == S_READ) && (rd_cnt == RD_LAST);
    mem_wen  = (state == S_WRITE);
    ap_done  = (state == S_DONE);
    mem_addr = '0;
    mem_datw = '0;
    if (state == S_READ) mem_addr = ADDR_W'(BASE_ADDR) + rd_cnt;
    if (state == S_WRITE) begin
      mem_addr = ADDR_W'(RES_ADDR);
      mem_datw = acc;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_cnt <= '0;
      wt_cnt <= '0;
    end else begin
      rd_cnt <= (state == S_READ) ? rd_cnt + ADDR_W'(1) : '0;
      wt_cnt <= (state == S_WAIT) ? wt_cnt + WT_W'(1) : '0;
    end
  end

  // one valid bit per issued read, emerging when its data is on mem_datr
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_pipe <= '0;
    end else begin
      vld_pipe[1] <= mem_ren;
      for (int s = 2; s <= MEM_LAT; s++) vld_pipe[s] <= vld_pipe[s-1];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      acc      <= '0;
      overflow <= 1'b0;
    end else if (start_txn) begin
      acc      <= '0;
      overflow <= 1'b0;
    end else if (vld_pipe[MEM_LAT]) begin
      acc      <= acc_sum[DATA_W-1:0];
      overflow <= overflow | acc_sum[DATA_W];
    end
  end

  always_ff @(posedge clk) begin
    if (rst)                  sum_out <= '0;
    else if (state == S_WRITE) sum_out <= acc;
  end

endmodule
